// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file writeback arbiter slice.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic             valid;
    reg_addr_t        addr;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request/grant bus plus the register file write port it drives.
interface rf_wb_arbiter_if #(parameter int XLEN = rf_pkg::XLEN);
  import rf_pkg::*;

  logic            wb0_valid;
  reg_addr_t       wb0_addr;
  logic [XLEN-1:0] wb0_data;
  logic            wb0_ready;

  logic            wb1_valid;
  reg_addr_t       wb1_addr;
  logic [XLEN-1:0] wb1_data;
  logic            wb1_ready;

  logic            rf_we;
  reg_addr_t       rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  // The arbiter is the slave of the writeback sources and drives the register file.
  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    output wb0_ready, wb1_ready,
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    input  wb0_ready, wb1_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for registers x1..x31 awaiting a long-latency writeback.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  reg_addr_t           set_addr,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  input  reg_addr_t           rs1,
  input  reg_addr_t           rs2,
  input  reg_addr_t           rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:1] busy_d;

  // The set is applied after the clear so a same-cycle set/clear leaves the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && (clr_addr != '0)) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != '0)) begin
      busy_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy  = {busy_q, 1'b0};
  assign stall = busy[rs1] | busy[rs2] | busy[rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-source register file writeback arbiter with starvation guard and busy scoreboard.
// Optional forwarding outputs are enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = rf_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  rf_wb_arbiter_if.slave   wb,
  input  logic             sb_set,
  input  reg_addr_t        sb_rd,
  input  reg_addr_t        dec_rs1,
  input  reg_addr_t        dec_rs2,
  input  reg_addr_t        dec_rd,
  output logic             dec_stall,
  output logic [3:0]       starve_cnt
`ifdef RF_WB_FWD_EN
  ,
  output logic             fwd_hit0,
  output logic             fwd_hit1,
  output logic [XLEN-1:0]  fwd_data
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_req_t             req0;
  wb_req_t             req1;
  wb_req_t             sel;
  logic                grant0;
  logic                grant1;
  logic [3:0]          starve_q;
  logic [3:0]          starve_d;
  logic [XLEN-1:0]     wdata_sel;
  logic [NUM_REGS-1:0] busy;

  // Requests are masked by reset so nothing is granted while rst_n is low.
  always_comb begin
    req0     = '{valid: wb.wb0_valid & rst_n, addr: wb.wb0_addr, data: wb.wb0_data};
    req1     = '{valid: wb.wb1_valid & rst_n, addr: wb.wb1_addr, data: wb.wb1_data};
    grant0   = 1'b0;
    grant1   = 1'b0;
    sel      = '0;
    starve_d = '0;
    if (req0.valid && req1.valid) begin
      if (starve_q == LIMIT) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else if (req0.valid) begin
      grant0 = 1'b1;
    end else if (req1.valid) begin
      grant1 = 1'b1;
    end
    if (grant0) begin
      sel = req0;
    end else if (grant1) begin
      sel = req1;
    end
    if (req1.valid && !grant1) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign wdata_sel    = sel.data;
  assign wb.wb0_ready = grant0;
  assign wb.wb1_ready = grant1;
  assign wb.rf_we     = sel.valid & (sel.addr != '0);
  assign wb.rf_waddr  = sel.addr;
  assign wb.rf_wdata  = wdata_sel;
  assign starve_cnt   = starve_q;

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set),
    .set_addr (sb_rd),
    .clr_en   (grant1),
    .clr_addr (req1.addr),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .stall    (dec_stall),
    .busy     (busy)
  );

`ifdef RF_WB_FWD_EN
  assign fwd_hit0 = wb.rf_we & (wb.rf_waddr == dec_rs1);
  assign fwd_hit1 = wb.rf_we & (wb.rf_waddr == dec_rs2);
  assign fwd_data = wb.rf_wdata;
`endif

  // Decode stalls on busy registers, so an in-order write to one means a broken stall path.
  wb0_busy_write : assert property (@(posedge clk) disable iff (!rst_n)
    (grant0 && (req0.addr != '0)) |-> !busy[req0.addr]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sb_set;
  reg_addr_t  sb_rd;
  reg_addr_t  dec_rs1;
  reg_addr_t  dec_rs2;
  reg_addr_t  dec_rd;
  logic       dec_stall;
  logic [3:0] starve_cnt;
`ifdef RF_WB_FWD_EN
  logic        fwd_hit0;
  logic        fwd_hit1;
  logic [31:0] fwd_data;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  bit mBusy[32];
  int mWait;

  rf_wb_arbiter_if #(.XLEN(32)) bus ();

  rf_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (bus.slave),
    .sb_set     (sb_set),
    .sb_rd      (sb_rd),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_rd     (dec_rd),
    .dec_stall  (dec_stall),
    .starve_cnt (starve_cnt)
`ifdef RF_WB_FWD_EN
    ,
    .fwd_hit0   (fwd_hit0),
    .fwd_hit1   (fwd_hit1),
    .fwd_data   (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit modelStall(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd);
    return mBusy[rs1] || mBusy[rs2] || mBusy[rd];
  endfunction

  // Drive one cycle of inputs at the falling edge, check just after, then advance the model.
  task automatic applyStimulus(
    input logic v0, input reg_addr_t a0, input logic [31:0] d0,
    input logic v1, input reg_addr_t a1, input logic [31:0] d1,
    input logic sSet, input reg_addr_t sRd,
    input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd);
    bit          g0, g1, eWe, eStall;
    reg_addr_t   eAddr;
    logic [31:0] eData;
    bus.wb0_valid = v0;  bus.wb0_addr = a0;  bus.wb0_data = d0;
    bus.wb1_valid = v1;  bus.wb1_addr = a1;  bus.wb1_data = d1;
    sb_set = sSet;  sb_rd = sRd;
    dec_rs1 = rs1;  dec_rs2 = rs2;  dec_rd = rd;
    #1;
    if (!rst_n) begin
      foreach (mBusy[i]) mBusy[i] = 1'b0;
      mWait = 0;
    end
    if (rst_n && v0 && v1) begin
      g1 = (mWait >= STARVE_LIMIT);
      g0 = !g1;
    end else begin
      g0 = rst_n && v0;
      g1 = rst_n && v1 && !v0;
    end
    eAddr  = g0 ? a0 : (g1 ? a1 : 5'd0);
    eData  = g0 ? d0 : (g1 ? d1 : 32'd0);
    eWe    = (g0 || g1) && (eAddr != 0);
    eStall = modelStall(rs1, rs2, rd);
    checkOutput("wb0_ready", {31'd0, bus.wb0_ready}, {31'd0, g0});
    checkOutput("wb1_ready", {31'd0, bus.wb1_ready}, {31'd0, g1});
    checkOutput("rf_we", {31'd0, bus.rf_we}, {31'd0, eWe});
    checkOutput("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, eAddr});
    checkOutput("rf_wdata", bus.rf_wdata, eData);
    checkOutput("dec_stall", {31'd0, dec_stall}, {31'd0, eStall});
    checkOutput("starve_cnt", {28'd0, starve_cnt}, 32'(mWait));
`ifdef RF_WB_FWD_EN
    checkOutput("fwd_hit0", {31'd0, fwd_hit0}, {31'd0, eWe && (eAddr == rs1)});
    checkOutput("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, eWe && (eAddr == rs2)});
    checkOutput("fwd_data", fwd_data, eData);
`endif
    if (rst_n) begin
      mWait = (v1 && !g1) ? ((mWait + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mWait + 1) : 0;
      if (g1 && a1 != 0) mBusy[a1] = 1'b0;
      if (sSet && sRd != 0) mBusy[sRd] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    reg_addr_t   a0, a1, rs1, rs2, rd;
    logic        v0, v1, sSet;
    rst_n = 1'b0;
    mWait = 0;
    foreach (mBusy[i]) mBusy[i] = 1'b0;
    @(negedge clk);

    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 32'h100 + 32'(i), 1, 2, 32'h200 + 32'(i), 0, 0, 0, 0, 0);
    end

    applyStimulus(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    applyStimulus(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 9);
    applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);

    applyStimulus(1, 3, 32'h55, 0, 0, 0, 0, 0, 3, 0, 0);
    applyStimulus(1, 0, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 11);
    rst_n = 1'b0;
    applyStimulus(1, 4, 32'h44, 1, 11, 32'hBB, 0, 0, 0, 0, 11);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11);

    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      a0 = 5'($urandom_range(0, 31));
      if (mBusy[a0]) a0 = 5'd0;
      v1 = 1'($urandom_range(0, 1));
      a1 = 5'($urandom_range(0, 31));
      for (int k = 0; k < 4 && !mBusy[a1]; k++) a1 = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      rd  = 5'($urandom_range(0, 31));
      sSet = ($urandom_range(0, 2) == 0) && !modelStall(rs1, rs2, rd);
      applyStimulus(v0, a0, $urandom, v1, a1, $urandom, sSet, rd, rs1, rs2, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources and tracks registers with pending long-latency writes.
- Source 0 is the in-order pipeline writeback (ALU/jump). Source 1 is the multi-cycle unit writeback (load/mul/div).
- Sits between the execute/writeback stages and the register file. Drives the register file's we/waddr/wdata.
- Gives the decode stage a hazard (stall) indication from a 31-entry busy scoreboard.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles source 1 may be refused before it takes priority over source 0 (range 1..15).
- XLEN, 32, register data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb0_valid  in  1  source 0 write request.
- wb0_addr  in  5  source 0 destination register.
- wb0_data  in  XLEN  source 0 write data.
- wb0_ready  out  1  source 0 granted this cycle.
- wb1_valid  in  1  source 1 write request.
- wb1_addr  in  5  source 1 destination register.
- wb1_data  in  XLEN  source 1 write data.
- wb1_ready  out  1  source 1 granted this cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  XLEN  register file write data.
- sb_set  in  1  decode issues a long-latency op this cycle (marks sb_rd busy).
- sb_rd  in  5  destination of the issuing long-latency op.
- dec_rs1  in  5  decode source register 1.
- dec_rs2  in  5  decode source register 2.
- dec_rd  in  5  decode destination register.
- dec_stall  out  1  busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd].
- starve_cnt  out  4  current source 1 wait count (debug).

Behaviour:
- Reset (async, rst_n low):
  - busy[31:1] = 0, starve counter = 0.
  - All outputs therefore 0: rf_we=0, wb0_ready=0, wb1_ready=0, dec_stall=0, rf_waddr=0, rf_wdata=0.
- Arbitration, combinational within a cycle, zero latency. Handshake completes in the cycle where valid & ready are both high.
  - Only one source valid: that source granted.
  - Both valid, starve counter < STARVE_LIMIT: source 0 granted; source 1 ready=0.
  - Both valid, starve counter == STARVE_LIMIT: source 1 granted; source 0 ready=0.
  - No grant: rf_we=0, rf_waddr=0, rf_wdata=0.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle wb1_valid=1 and wb1_ready=0.
  - Clears to 0 on a source 1 grant, or when wb1_valid=0.
- Write port:
  - rf_waddr/rf_wdata = granted source's addr/data.
  - rf_we = grant & (addr != 0). Writes to x0 complete the handshake but never assert rf_we.
  - The register file commits on the same rising edge, so the write is visible to reads the following cycle.
- Scoreboard (registered):
  - busy[a] sets on sb_set with sb_rd=a, a≠0.
  - busy[a] clears on a completed source 1 handshake with wb1_addr=a.
  - Set and clear of the same address in the same cycle: set wins, busy stays 1.
  - sb_set with sb_rd=0 is ignored. busy[0] reads as 0 always.
- dec_stall:
  - Combinational from the current registered busy bits only. A clear takes effect on the cycle after the source 1 handshake.
  - Decode must not assert sb_set while dec_stall=1. Covering busy[dec_rd] removes WAW hazards.
- Source 0 writing a register whose busy bit is set is illegal (prevented by the stall). Simulation assertion flags it.
- Reset mid-operation clears all pending busy bits immediately. Requesters are reset alongside and re-issue nothing.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Defined: adds outputs fwd_hit0, fwd_hit1 (1 bit each) and fwd_data (XLEN).
  - fwd_hitN = rf_we & (rf_waddr == dec_rsN).
  - fwd_data = rf_wdata.
  - Decode muxes fwd_data over register file read data when the hit bit is set, removing the one-cycle write-to-read gap.
  - dec_stall is unchanged.
- Undefined: ports absent, no forwarding logic. Decode sees the write one cycle after the grant.

Decomposition:
- Package rf_pkg holds:
  - REG_ADDR_W=5, NUM_REGS=32, XLEN default.
  - typedef reg_addr_t.
  - typedef wb_req_t {valid, addr, data}.
- One natural sub-module: rf_scoreboard (busy vector, set/clear/query, 31 flops). The arbiter top instantiates it.

Test Plan:
- Reset with wb0_valid=1: all outputs 0 while rst_n=0. After release, wb0_valid=1, addr=5, data=0xDEADBEEF gives wb0_ready=1, rf_we=1, rf_waddr=5 in the same cycle.
- Both sources valid continuously, STARVE_LIMIT=4: source 0 granted cycles 0–3, source 1 granted cycle 4, then starve_cnt returns to 0 and source 0 is granted again.
- wb1 write to x0 with data 0x1234: wb1_ready=1, rf_we=0. No busy bit changes.
- sb_set, sb_rd=7; next cycle dec_rs2=7 gives dec_stall=1. wb1 handshake to addr 7 gives dec_stall=0 the following cycle.
- Same cycle: sb_set with sb_rd=9 and wb1 handshake to addr 9 (busy[9] already 1): busy[9] remains 1 and dec_rd=9 stalls.
- RF_WB_FWD_EN: wb0 writes x3=0x55 while dec_rs1=3 gives fwd_hit0=1, fwd_data=0x55. With dec_rs1=0 and a grant to x0, fwd_hit0=0.
